// File: rtl/cmd_regbank.sv
// Command-frame register bank.
// Consumes decoded command frames (write / read), keeps a bank of NREGS
// registers of DW bits each, and produces one response frame per command.
module cmd_regbank #(
  parameter int              DW        = 24,
  parameter int              NREGS     = 16,
  parameter logic [DW-1:0]   RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_last,
  output logic [7:0]          o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic [NREGS*DW-1:0] regs,
  output logic                wr_strobe,
  output logic [7:0]          wr_addr
);

  localparam int         NB      = DW / 8;
  localparam logic [2:0] NB_LAST = 3'(NB - 1);
  localparam logic [2:0] LEN_RD  = 3'(NB + 2);
  localparam logic [2:0] LEN_2   = 3'd2;
  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_DROP = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Error code with fixed priority: bad opcode, then length, then address.
  function automatic logic [7:0] err_code(input logic e_op, input logic e_len, input logic e_addr);
    logic [7:0] c;
    if (e_op) begin
      c = 8'h01;
    end else if (e_len) begin
      c = 8'h03;
    end else if (e_addr) begin
      c = 8'h02;
    end else begin
      c = 8'h00;
    end
    return c;
  endfunction

  state_t          state, state_nx;
  logic [7:0]      op, op_nx;
  logic [7:0]      addr, addr_nx;
  logic [DW-1:0]   shadow, shadow_nx;
  logic [2:0]      cnt, cnt_nx;
  logic            err_op, err_op_nx;
  logic            err_len, err_len_nx;
  logic            err_addr, err_addr_nx;
  logic            commit;
  logic            xfer;
  logic            enter_resp;
  logic            any_err_nx;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rd_sel;
  logic [DW-1:0]   reg_q [NREGS];

  // Response frame context captured on RESP entry.
  logic [7:0]      r_hdr;
  logic [7:0]      r_b1;
  logic [2:0]      r_len;
  logic [2:0]      r_idx;
  logic [DW-1:0]   rd_sh;

  assign xfer       = i_valid & o_ready;
  assign wdata      = (shadow << 8) | DW'(i_data);
  assign enter_resp = (state_nx == S_RESP) && (state != S_RESP);
  assign any_err_nx = err_op_nx | err_len_nx | err_addr_nx;

  genvar g;
  for (g = 0; g < NREGS; g++) begin : g_flat
    assign regs[g*DW +: DW] = reg_q[g];
  end

  // Frame parser: next state, latched fields, error flags and write commit.
  always_comb begin
    state_nx    = state;
    op_nx       = op;
    addr_nx     = addr;
    shadow_nx   = shadow;
    cnt_nx      = cnt;
    err_op_nx   = err_op;
    err_len_nx  = err_len;
    err_addr_nx = err_addr;
    commit      = 1'b0;
    case (state)
      S_CMD: begin
        if (xfer) begin
          op_nx       = i_data;
          addr_nx     = 8'h00;
          shadow_nx   = '0;
          cnt_nx      = 3'd0;
          err_op_nx   = 1'b0;
          err_len_nx  = 1'b0;
          err_addr_nx = 1'b0;
          if ((i_data != OP_WR) && (i_data != OP_RD)) begin
            err_op_nx = 1'b1;
            state_nx  = i_last ? S_RESP : S_DROP;
          end else if (i_last) begin
            err_len_nx = 1'b1;
            state_nx   = S_RESP;
          end else begin
            state_nx = S_ADDR;
          end
        end else begin
          state_nx = S_CMD;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          addr_nx     = i_data;
          err_addr_nx = ({1'b0, i_data} >= 9'(NREGS));
          if (op == OP_RD) begin
            if (i_last) begin
              state_nx = S_RESP;
            end else begin
              err_len_nx = 1'b1;
              state_nx   = S_DROP;
            end
          end else begin
            if (i_last) begin
              err_len_nx = 1'b1;
              state_nx   = S_RESP;
            end else begin
              state_nx = S_DATA;
            end
          end
        end else begin
          state_nx = S_ADDR;
        end
      end
      S_DATA: begin
        if (xfer) begin
          shadow_nx = wdata;
          cnt_nx    = cnt + 3'd1;
          if (cnt == NB_LAST) begin
            if (i_last) begin
              state_nx = S_RESP;
              commit   = ~(err_op | err_len | err_addr);
            end else begin
              err_len_nx = 1'b1;
              state_nx   = S_DROP;
            end
          end else if (i_last) begin
            err_len_nx = 1'b1;
            state_nx   = S_RESP;
          end else begin
            state_nx = S_DATA;
          end
        end else begin
          state_nx = S_DATA;
        end
      end
      S_DROP: begin
        if (xfer) begin
          cnt_nx   = (cnt == 3'd7) ? cnt : cnt + 3'd1;
          state_nx = i_last ? S_RESP : S_DROP;
        end else begin
          state_nx = S_DROP;
        end
      end
      S_RESP: begin
        if (o_valid && i_ready && o_last) begin
          state_nx = S_CMD;
        end else begin
          state_nx = S_RESP;
        end
      end
      default: begin
        state_nx = S_CMD;
      end
    endcase
  end

  // Read snapshot source; forwards a write committing on the same edge.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NREGS; k++) begin
      rd_sel = (addr_nx == 8'(k)) ? reg_q[k] : rd_sel;
    end
    if (commit && (addr == addr_nx)) begin
      rd_sel = wdata;
    end else begin
      rd_sel = rd_sel;
    end
  end

  // Parser state and frame fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_CMD;
      op       <= 8'h00;
      addr     <= 8'h00;
      shadow   <= '0;
      cnt      <= 3'd0;
      err_op   <= 1'b0;
      err_len  <= 1'b0;
      err_addr <= 1'b0;
      o_ready  <= 1'b0;
    end else begin
      state    <= state_nx;
      op       <= op_nx;
      addr     <= addr_nx;
      shadow   <= shadow_nx;
      cnt      <= cnt_nx;
      err_op   <= err_op_nx;
      err_len  <= err_len_nx;
      err_addr <= err_addr_nx;
      o_ready  <= (state_nx != S_RESP);
    end
  end

  // Register bank update and write notification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        reg_q[k] <= RESET_VAL;
      end
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (commit && (addr == 8'(k))) begin
          reg_q[k] <= wdata;
        end else begin
          reg_q[k] <= reg_q[k];
        end
      end
      wr_strobe <= commit;
      wr_addr   <= commit ? addr : wr_addr;
    end
  end

  // Response emitter: captures the frame on RESP entry, then streams it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= 8'h00;
      r_hdr   <= 8'h00;
      r_b1    <= 8'h00;
      r_len   <= 3'd0;
      r_idx   <= 3'd0;
      rd_sh   <= '0;
    end else if (enter_resp) begin
      r_hdr   <= any_err_nx ? 8'hEE : ((op_nx == OP_RD) ? 8'h82 : 8'h81);
      r_b1    <= any_err_nx ? err_code(err_op_nx, err_len_nx, err_addr_nx) : addr_nx;
      r_len   <= (!any_err_nx && (op_nx == OP_RD)) ? LEN_RD : LEN_2;
      r_idx   <= 3'd0;
      rd_sh   <= rd_sel;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (state == S_RESP) begin
      if (!o_valid) begin
        o_valid <= 1'b1;
        o_data  <= r_hdr;
        o_last  <= 1'b0;
        r_idx   <= 3'd0;
      end else if (i_ready) begin
        if (o_last) begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end else begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd0) begin
            o_data <= r_b1;
            o_last <= (r_len == LEN_2);
          end else begin
            o_data <= rd_sh[DW-1 -: 8];
            rd_sh  <= rd_sh << 8;
            o_last <= ((r_idx + 3'd1) == (r_len - 3'd1));
          end
        end
      end else begin
        o_data <= o_data;
      end
    end else begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmd_regbank.sv
// Directed bench for cmd_regbank (DW=24, NREGS=16, RESET_VAL=0).
module tb_cmd_regbank;

  localparam int DW    = 24;
  localparam int NREGS = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          i_data;
  logic                i_valid;
  logic                o_ready;
  logic                i_last;
  logic [7:0]          o_data;
  logic                o_valid;
  logic                i_ready;
  logic                o_last;
  logic [NREGS*DW-1:0] regs;
  logic                wr_strobe;
  logic [7:0]          wr_addr;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [7:0] last_wr_addr = 8'h00;
  logic [NREGS*DW-1:0] saved_regs;

  cmd_regbank #(.DW(DW), .NREGS(NREGS), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  // Count committed writes seen on the clock edge.
  always @(posedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt   = strobe_cnt + 1;
      last_wr_addr = wr_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    chk("no_early_resp", {31'd0, o_valid}, 32'd0);
    i_data  = b;
    i_valid = 1'b1;
    i_last  = last;
    while (o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
  endtask

  task automatic recv(input logic [7:0] exp[$], input bit bp);
    logic [7:0] got[$];
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;
    bit         stall = 1'b0;
    bit         done = 1'b0;
    int         n = 0;
    while (!done && n < 400) begin
      i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid === 1'b1) begin
        chk("ready_low_in_resp", {31'd0, o_ready}, 32'd0);
        if (stall) begin
          chk("stable_data", {24'd0, o_data}, {24'd0, pd});
          chk("stable_last", {31'd0, o_last}, {31'd0, pl});
        end
        if (i_ready) begin
          got.push_back(o_data);
          chk("o_last_pos", {31'd0, o_last}, {31'd0, got.size() == exp.size()});
          if (o_last === 1'b1 || got.size() > 8) done = 1'b1;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          pd    = o_data;
          pl    = o_last;
        end
      end
      @(negedge clk);
      n++;
    end
    i_ready = 1'b0;
    chk("resp_done", {31'd0, done}, 32'd1);
    chk("resp_len", got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk("resp_byte", (i < got.size()) ? {24'd0, got[i]} : 32'hxxxxxxxx, {24'd0, exp[i]});
    chk("ready_after_resp", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic transact(input logic [7:0] frame[$], input logic [7:0] exp[$], input bit bp);
    send_frame(frame);
    chk("resp_gap_valid", {31'd0, o_valid}, 32'd0);
    chk("resp_gap_ready", {31'd0, o_ready}, 32'd0);
    recv(exp, bp);
  endtask

  initial begin
    rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_last", {31'd0, o_last}, 32'd0);
    chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_regs", {31'd0, regs === '0}, 32'd1);
    rst = 1'b0;
    #1 chk("ready_before_edge", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // Write then read back.
    transact('{8'h01, 8'h03, 8'h12, 8'h34, 8'h56}, '{8'h81, 8'h03}, 1'b0);
    chk("reg3", regs[3*DW +: DW], 32'h123456);
    chk("strobe_once", strobe_cnt, 32'd1);
    chk("strobe_addr", {24'd0, last_wr_addr}, 32'd3);
    transact('{8'h02, 8'h03}, '{8'h82, 8'h03, 8'h12, 8'h34, 8'h56}, 1'b0);

    // Out-of-range address.
    saved_regs = regs;
    transact('{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC}, '{8'hEE, 8'h02}, 1'b0);
    chk("oor_no_strobe", strobe_cnt, 32'd1);
    chk("oor_regs", {31'd0, regs === saved_regs}, 32'd1);

    // Length errors.
    transact('{8'h01, 8'h02, 8'hAA}, '{8'hEE, 8'h03}, 1'b0);
    transact('{8'h02, 8'h02, 8'h00, 8'h00}, '{8'hEE, 8'h03}, 1'b0);
    transact('{8'h01}, '{8'hEE, 8'h03}, 1'b0);
    chk("len_no_strobe", strobe_cnt, 32'd1);
    chk("len_regs", {31'd0, regs === saved_regs}, 32'd1);

    // Bad opcode, answered only after the last byte.
    transact('{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, '{8'hEE, 8'h01}, 1'b0);

    // Backpressure on a read, then an immediate next frame.
    transact('{8'h01, 8'h05, 8'hA5, 8'h5A, 8'h0F}, '{8'h81, 8'h05}, 1'b0);
    transact('{8'h02, 8'h05}, '{8'h82, 8'h05, 8'hA5, 8'h5A, 8'h0F}, 1'b1);
    transact('{8'h02, 8'h03}, '{8'h82, 8'h03, 8'h12, 8'h34, 8'h56}, 1'b1);
    chk("strobe_two", strobe_cnt, 32'd2);

    // Reset during the third byte of a write.
    send_byte(8'h01, 1'b0);
    send_byte(8'h07, 1'b0);
    i_data = 8'h11; i_valid = 1'b1; rst = 1'b1;
    #1 chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
    chk("mid_rst_regs", {31'd0, regs === '0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", {31'd0, o_valid}, 32'd0);
    end
    chk("mid_rst_no_strobe", strobe_cnt, 32'd2);
    transact('{8'h01, 8'h07, 8'hDE, 8'hAD, 8'h01}, '{8'h81, 8'h07}, 1'b0);
    chk("post_rst_reg7", regs[7*DW +: DW], 32'hDEAD01);
    chk("post_rst_reg3", regs[3*DW +: DW], 32'h000000);
    transact('{8'h02, 8'h07}, '{8'h82, 8'h07, 8'hDE, 8'hAD, 8'h01}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_regbank.md
CMD_REGBANK -- requirements
Module: cmd_regbank

Interface
REQ-001 SHALL have parameter DW, default 24: register width in bits; must be a multiple of 8, range 8..32.
REQ-002 SHALL have parameter NREGS, default 16: register count, range 1..256.
REQ-003 SHALL have parameter RESET_VAL, default 0: reset value of every register.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports i_data (input, 8), i_valid (input, 1), o_ready (output, 1) and i_last (input, 1): the decoded command byte stream, with i_last marking the final byte of a frame.
REQ-007 SHALL have ports o_data (output, 8), o_valid (output, 1), i_ready (input, 1) and o_last (output, 1): the response byte stream, intended for a COBS encoder.
REQ-008 SHALL have port regs, output, NREGS*DW bits: the flattened register bank, with register k at bits [k*DW +: DW].
REQ-009 SHALL have ports wr_strobe (output, 1) and wr_addr (output, 8): a one-cycle pulse and the address of each committed write.

Function
REQ-010 SHALL treat a byte as transferred only on a cycle where valid and ready are both high; this applies to both streams.
REQ-011 SHALL use this frame format: byte0 opcode (0x01 write, 0x02 read); byte1 address; write frames then carry DW/8 data bytes, MSB first; read frames end at byte1.
REQ-012 SHALL implement states CMD, ADDR, DATA, DROP and RESP; the reset state is CMD.
REQ-013 SHALL, in CMD, ADDR, DATA and DROP, hold o_ready=1; in RESP it SHALL hold o_ready=0.
REQ-014 CMD SHALL latch the opcode and go to ADDR; if i_last is set on that byte, it SHALL go to RESP with error 0x03.
REQ-015 ADDR SHALL latch the address and flag it as bad if address >= NREGS.
REQ-016 For a read, ADDR with i_last SHALL go to RESP; ADDR without i_last SHALL go to DROP with error 0x03.
REQ-017 For a write, ADDR with i_last SHALL go to RESP with error 0x03; otherwise it SHALL go to DATA.
REQ-018 DATA SHALL shift bytes into the write shadow register, MSB first, counting bytes.
- i_last before the final byte: go to RESP with error 0x03.
- Final byte without i_last: go to DROP with error 0x03.
- Final byte with i_last: go to RESP.
REQ-019 An invalid opcode SHALL go to DROP with error 0x01, unless i_last is set on that byte, in which case it SHALL go to RESP with error 0x01.
REQ-020 DROP SHALL discard bytes until a transfer with i_last, then go to RESP.
REQ-021 Error priority SHALL be 0x01 over 0x03 over 0x02.
REQ-022 Any error SHALL inhibit the register write.
REQ-023 A valid write SHALL update the target register on the clock edge that follows the final byte transfer, with wr_strobe high for exactly that cycle.
REQ-024 RESP SHALL emit the response frame, with o_valid first asserted the cycle after entering RESP:
- Write acknowledge: [0x81, addr].
- Read: [0x82, addr, DW/8 data bytes MSB first].
- Error: [0xEE, code].
REQ-025 RESP SHALL assert o_last on the final byte only.
REQ-026 Read data SHALL be snapshotted on RESP entry; a write committed in the same cycle SHALL be visible in the snapshot.
REQ-027 o_data and o_last SHALL stay stable while o_valid=1 and i_ready=0.
REQ-028 RESP SHALL return to CMD after the final byte transfers; back-to-back frames SHALL lose no cycles beyond the response.
REQ-029 The byte counter SHALL saturate in DROP; any frame length SHALL be accepted without counter wrap effects.

Reset
REQ-030 Asserting rst SHALL immediately force state to CMD.
REQ-031 Asserting rst SHALL force regs to RESET_VAL, and force o_valid, o_last and wr_strobe to 0.
REQ-032 Asserting rst SHALL force o_ready to 0, and also clear the opcode, address and shadow registers and the error flags.
REQ-033 o_ready SHALL rise on the first clock edge after rst deasserts.
REQ-034 Reset mid-frame or mid-response SHALL abandon the frame with no write and no further response bytes.

Verification
REQ-035 Write then read: stimulus [01 03 12 34 56] then [02 03] -> responses [81 03] and [82 03 12 34 56], wr_strobe pulses once, and regs[3]=0x123456.
REQ-036 Address out of range: stimulus [01 10 AA BB CC] with NREGS=16 -> response [EE 02]; no wr_strobe; regs unchanged.
REQ-037 Length errors:
- [01 02 AA] -> response [EE 03].
- [02 02 00 00] -> response [EE 03].
- [01] -> response [EE 03].
- In all three cases, no write occurs.
REQ-038 Bad opcode: stimulus [7F 00 00 00 00 00] -> response [EE 01], issued only after the last input byte.
REQ-039 Backpressure: a read with i_ready toggling randomly -> the output bytes are stable and complete, o_ready stays 0 throughout RESP, and the next frame is accepted immediately afterwards.
REQ-040 Reset mid-operation: assert rst during the third byte of a write -> regs=RESET_VAL, no response, and a subsequent valid frame is processed normally.
